hpd_monitor: RTL and testbench

- Watches the DisplayPort hot-plug-detect (HPD) line from the sink.
- Debounces plug and unplug, and classifies short low pulses as IRQ_HPD.
- Presents link-presence status plus sticky event bits to the register file.
- Its events gate the training logic: start training on plug, retrain or read sink status on IRQ.
- Sits in the fclk[0] domain beside the aux channel, directly upstream of the training block.

---
 rtl/hpd_monitor.sv | 151 +++++++++++++++
 tb/tb_hpd_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hpd_monitor.sv
// DisplayPort HPD monitor: synchronises and debounces the sink's hot-plug line,
// separates IRQ_HPD low pulses from unplugs, and keeps sticky event status.
module hpd_monitor #(
    parameter int CLKMHZ     = 100,
    parameter int PLUG_US    = 2000,
    parameter int IRQ_MIN_US = 250,
    parameter int IRQ_MAX_US = 2000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        hpd_in,
    output logic        connected,
    output logic        plug_pulse,
    output logic        unplug_pulse,
    output logic        irq_pulse,
    output logic [2:0]  sts,
    input  logic [2:0]  stsclr,
    output logic [15:0] lowlen
);

    if (IRQ_MIN_US > IRQ_MAX_US || IRQ_MAX_US >= 65535 || PLUG_US >= 65535) begin : g_param_err
        $error("hpd_monitor: illegal timing parameters");
    end

    localparam int PW = (CLKMHZ > 1) ? $clog2(CLKMHZ) : 1;
    localparam logic [PW-1:0] PRE_MAX     = PW'(CLKMHZ - 1);
    localparam logic [15:0]   PLUG_CNT    = 16'(PLUG_US);
    localparam logic [15:0]   IRQ_MIN_CNT = 16'(IRQ_MIN_US);
    localparam logic [15:0]   UNPLUG_CNT  = 16'(IRQ_MAX_US + 1);

    localparam logic [1:0] ST_DISC     = 2'd0;
    localparam logic [1:0] ST_PLUGWAIT = 2'd1;
    localparam logic [1:0] ST_CONN     = 2'd2;
    localparam logic [1:0] ST_LOW      = 2'd3;

    logic          sync1_q, hpd_s_q;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   cnt_q, cnt_d, cnt_n;
    logic          connected_q, connected_d;
    logic          plug_q, plug_d;
    logic          unplug_q, unplug_d;
    logic          irq_q, irq_d;
    logic [2:0]    sts_q, sts_d;
    logic [15:0]   lowlen_q, lowlen_d;
    logic          tick, enter;

    always_comb begin
        tick        = (pre_q == PRE_MAX);
        // Decisions use the count including this cycle's tick, so a threshold
        // is acted on at the same edge the counter reaches it.
        cnt_n       = (tick && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        state_d     = state_q;
        pre_d       = tick ? '0 : pre_q + PW'(1);
        cnt_d       = cnt_n;
        connected_d = connected_q;
        plug_d      = 1'b0;
        unplug_d    = 1'b0;
        irq_d       = 1'b0;
        lowlen_d    = lowlen_q;
        enter       = 1'b0;

        case (state_q)
            ST_DISC: begin
                if (hpd_s_q) begin
                    state_d = ST_PLUGWAIT;
                    enter   = 1'b1;
                end
            end
            ST_PLUGWAIT: begin
                if (!hpd_s_q) begin
                    state_d = ST_DISC;
                    enter   = 1'b1;
                end else if (cnt_n >= PLUG_CNT) begin
                    state_d     = ST_CONN;
                    connected_d = 1'b1;
                    plug_d      = 1'b1;
                    enter       = 1'b1;
                end
            end
            ST_CONN: begin
                if (!hpd_s_q) begin
                    state_d = ST_LOW;
                    enter   = 1'b1;
                end
            end
            default: begin
                // Timeout checked first: a rise on the very edge of expiry is an unplug.
                if (cnt_n >= UNPLUG_CNT) begin
                    state_d     = ST_DISC;
                    connected_d = 1'b0;
                    unplug_d    = 1'b1;
                    lowlen_d    = UNPLUG_CNT;
                    enter       = 1'b1;
                end else if (hpd_s_q) begin
                    state_d = ST_CONN;
                    enter   = 1'b1;
                    if (cnt_n >= IRQ_MIN_CNT) begin
                        irq_d    = 1'b1;
                        lowlen_d = cnt_n;
                    end
                end
            end
        endcase

        if (enter) begin
            pre_d = '0;
            cnt_d = '0;
        end

        // Sets come from the registered strobes, so a clear landing in the same
        // cycle as a visible pulse still leaves the bit set.
        sts_d = (sts_q & ~stsclr) | {irq_q, unplug_q, plug_q};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= 1'b0;
            hpd_s_q     <= 1'b0;
            state_q     <= ST_DISC;
            pre_q       <= '0;
            cnt_q       <= '0;
            connected_q <= 1'b0;
            plug_q      <= 1'b0;
            unplug_q    <= 1'b0;
            irq_q       <= 1'b0;
            sts_q       <= '0;
            lowlen_q    <= '0;
        end else begin
            sync1_q     <= hpd_in;
            hpd_s_q     <= sync1_q;
            state_q     <= state_d;
            pre_q       <= pre_d;
            cnt_q       <= cnt_d;
            connected_q <= connected_d;
            plug_q      <= plug_d;
            unplug_q    <= unplug_d;
            irq_q       <= irq_d;
            sts_q       <= sts_d;
            lowlen_q    <= lowlen_d;
        end
    end

    assign connected    = connected_q;
    assign plug_pulse   = plug_q;
    assign unplug_pulse = unplug_q;
    assign irq_pulse    = irq_q;
    assign sts          = sts_q;
    assign lowlen       = lowlen_q;

endmodule

// File: tb/tb_hpd_monitor.sv
// Directed bench for hpd_monitor: stimulus queues expected HPD events, a
// negedge monitor pops and compares them whenever a pulse appears.
module tb_hpd_monitor;

    localparam int CLKMHZ     = 10;
    localparam int PLUG_US    = 20;
    localparam int IRQ_MIN_US = 5;
    localparam int IRQ_MAX_US = 20;
    // negedges from driving hpd_in until a plug strobe is visible
    localparam int PLUG_LAT   = PLUG_US * CLKMHZ + 3;
    localparam int EW         = 52;

    logic        clk = 1'b0;
    logic        resetn;
    logic        hpd_in;
    logic [2:0]  stsclr;
    logic        connected, plug_pulse, unplug_pulse, irq_pulse;
    logic [2:0]  sts;
    logic [15:0] lowlen;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int c0, c1;
    logic [EW-1:0] exp_q[$];

    hpd_monitor #(
        .CLKMHZ    (CLKMHZ),
        .PLUG_US   (PLUG_US),
        .IRQ_MIN_US(IRQ_MIN_US),
        .IRQ_MAX_US(IRQ_MAX_US)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .hpd_in      (hpd_in),
        .connected   (connected),
        .plug_pulse  (plug_pulse),
        .unplug_pulse(unplug_pulse),
        .irq_pulse   (irq_pulse),
        .sts         (sts),
        .stsclr      (stsclr),
        .lowlen      (lowlen)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // expected event: pulse vector {irq,unplug,plug}, negedge cycle it is seen, connected, lowlen
    task automatic expect_ev(input logic [2:0] p, input int c, input logic conn, input logic [15:0] ll);
        exp_q.push_back({32'(c), p, conn, ll});
    endtask

    task automatic low_pulse(input int n);
        hpd_in = 1'b0;
        step(n);
        hpd_in = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_connected"}, {31'd0, connected}, 32'd0);
        check({tag, "_pulses"}, {29'd0, irq_pulse, unplug_pulse, plug_pulse}, 32'd0);
        check({tag, "_sts"}, {29'd0, sts}, 32'd0);
        check({tag, "_lowlen"}, {16'd0, lowlen}, 32'd0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin : monitor
        logic [2:0]    p;
        logic [EW-1:0] e;
        if (resetn) begin
            p = {irq_pulse, unplug_pulse, plug_pulse};
            if (p != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {29'd0, p}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {29'd0, p}, {29'd0, e[19:17]});
                    check("pulse_cycle", cyc, e[51:20]);
                    check("pulse_connected", {31'd0, connected}, {31'd0, e[16]});
                    check("pulse_lowlen", {16'd0, lowlen}, {16'd0, e[15:0]});
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        miscompares++;
        $display("FAIL watchdog: run did not complete, got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : stimulus
        resetn = 1'b0;
        hpd_in = 1'b0;
        stsclr = 3'b000;
        step(3);
        check_all_zero("reset");
        resetn = 1'b1;
        step(2);

        // plug
        hpd_in = 1'b1;
        c0 = cyc;
        expect_ev(3'b001, c0 + PLUG_LAT, 1'b1, 16'd0);
        step(PLUG_LAT - 1);
        check("plug_not_early", {31'd0, connected}, 32'd0);
        step(2);
        check("plug_connected", {31'd0, connected}, 32'd1);
        check("plug_sts", {29'd0, sts}, 32'd1);
        stsclr = 3'b111;
        step(1);
        stsclr = 3'b000;
        check("sts_cleared", {29'd0, sts}, 32'd0);

        // IRQ, 80 cycles low -> 8 us
        c0 = cyc;
        expect_ev(3'b100, c0 + 83, 1'b1, 16'd8);
        low_pulse(80);
        step(10);
        check("irq_sts", {29'd0, sts}, 32'd4);
        check("irq_connected", {31'd0, connected}, 32'd1);
        check("irq_lowlen", {16'd0, lowlen}, 32'd8);
        stsclr = 3'b111;
        step(1);
        stsclr = 3'b000;

        // glitch, 30 cycles low -> 3 us, ignored
        low_pulse(30);
        step(10);
        check("glitch_lowlen", {16'd0, lowlen}, 32'd8);
        check("glitch_sts", {29'd0, sts}, 32'd0);
        check("glitch_connected", {31'd0, connected}, 32'd1);

        // exactly IRQ_MIN_US -> irq
        c0 = cyc;
        expect_ev(3'b100, c0 + 53, 1'b1, 16'd5);
        low_pulse(50);
        step(10);

        // one below IRQ_MIN_US -> glitch
        low_pulse(40);
        step(10);
        check("min_minus1_lowlen", {16'd0, lowlen}, 32'd5);

        // exactly IRQ_MAX_US -> irq
        c0 = cyc;
        expect_ev(3'b100, c0 + 203, 1'b1, 16'd20);
        low_pulse(200);
        step(10);
        check("max_lowlen", {16'd0, lowlen}, 32'd20);

        // rise on the expiry edge: unplug wins, then a fresh plug debounce
        c0 = cyc;
        expect_ev(3'b010, c0 + 213, 1'b0, 16'd21);
        expect_ev(3'b001, c0 + 414, 1'b1, 16'd21);
        low_pulse(210);
        step(215);
        check("replug_connected", {31'd0, connected}, 32'd1);
        check("replug_sts", {29'd0, sts}, 32'd7);
        stsclr = 3'b111;
        step(1);
        stsclr = 3'b000;

        // unplug, held low
        c0 = cyc;
        hpd_in = 1'b0;
        expect_ev(3'b010, c0 + 213, 1'b0, 16'd21);
        step(220);
        check("unplug_connected", {31'd0, connected}, 32'd0);
        check("unplug_sts", {29'd0, sts}, 32'd2);
        check("unplug_lowlen", {16'd0, lowlen}, 32'd21);

        // plug bounce: high 150, low 30, high
        c0 = cyc;
        hpd_in = 1'b1;
        step(150);
        hpd_in = 1'b0;
        step(30);
        hpd_in = 1'b1;
        c1 = cyc;
        expect_ev(3'b001, c1 + PLUG_LAT, 1'b1, 16'd21);
        step(c0 + PLUG_LAT - cyc);
        check("bounce_no_early_plug", {31'd0, connected}, 32'd0);
        step(c1 + PLUG_LAT + 5 - cyc);
        check("bounce_connected", {31'd0, connected}, 32'd1);

        // clear coinciding with a visible irq pulse: set wins on bit2, bit1 clears
        c0 = cyc;
        expect_ev(3'b100, c0 + 83, 1'b1, 16'd8);
        low_pulse(80);
        step(3);
        stsclr = 3'b110;
        step(1);
        stsclr = 3'b000;
        check("set_beats_clear_sts", {29'd0, sts}, 32'd5);

        // asynchronous reset in the middle of a low pulse
        hpd_in = 1'b0;
        step(100);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("reset_mid_low");
        @(negedge clk);
        hpd_in = 1'b1;
        step(2);
        resetn = 1'b1;
        c0 = cyc;
        expect_ev(3'b001, c0 + PLUG_LAT, 1'b1, 16'd0);
        step(PLUG_LAT - 1);
        check("post_reset_not_early", {31'd0, connected}, 32'd0);
        step(10);
        check("post_reset_connected", {31'd0, connected}, 32'd1);

        // asynchronous reset during plug debounce
        c0 = cyc;
        hpd_in = 1'b0;
        expect_ev(3'b010, c0 + 213, 1'b0, 16'd21);
        step(220);
        hpd_in = 1'b1;
        step(100);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("reset_mid_plugwait");
        @(negedge clk);
        step(2);
        resetn = 1'b1;
        c0 = cyc;
        expect_ev(3'b001, c0 + PLUG_LAT, 1'b1, 16'd0);
        step(PLUG_LAT + 7);
        check("final_connected", {31'd0, connected}, 32'd1);
        check("final_sts", {29'd0, sts}, 32'd1);

        step(5);
        check("expected_queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
